// File: rtl/partial_sum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
package partial_sum_acc_pkg;

  // Sequencing states of the row/channel walk
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  // Widest product the sign-extension helper handles
  localparam int SEXT_W  = 64;
  localparam int SEXT_IW = 6;

  // Accumulator width: product width plus 8 guard bits for window/channel growth
  function automatic int acc_width_of(input int bit_width);
    return 2 * bit_width + 8;
  endfunction

  // Replicate bit from_w-1 into every bit above it
  function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] val,
                                                    input int from_w);
    logic [SEXT_W-1:0] mask;
    mask = {SEXT_W{1'b1}} << from_w;
    return val[SEXT_IW'(from_w - 1)] ? (val | mask) : (val & ~mask);
  endfunction

endpackage

// File: rtl/psum_row_buffer.sv
// Per-row partial-sum storage: one entry per output pixel, read-modify-write
// on each window result, with the old content ignored on the first channel.
module psum_row_buffer
  import partial_sum_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int DEPTH     = 4,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_addr,
  input  logic                 i_clear,
  input  logic [ACC_WIDTH-1:0] i_add,
  output logic [ACC_WIDTH-1:0] o_rd_data
);

  logic [ACC_WIDTH-1:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[i_addr];

  // Accumulate the window result into its pixel slot; first channel starts from zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_addr] <= (i_clear ? '0 : r_mem[i_addr]) + i_add;
    end
  end

endmodule

// File: rtl/partial_sum_acc.sv
// Folds per-pixel kernel-column products into 1-D sliding-window sums with a
// transposed-FIR chain, accumulates them across input channels in a row
// buffer, and streams finished pixels out through a one-entry output register.
module partial_sum_acc
  import partial_sum_acc_pkg::*;
#(
  parameter int BIT_WIDTH            = 8,
  parameter int NO_COL_KERNEL        = 5,
  parameter int NO_COL_INPUT_FEATURE = 8,
  parameter int NO_IN_CHANNEL        = 2,
  parameter int ACC_WIDTH            = acc_width_of(BIT_WIDTH)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0] i_products,
  input  logic [NO_COL_KERNEL-1:0]             i_enable_core,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [ACC_WIDTH-1:0]                 o_psum,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_last,
  output logic                                 o_busy
);

  localparam int K    = NO_COL_KERNEL;
  localparam int W    = NO_COL_INPUT_FEATURE;
  localparam int PW   = 2 * BIT_WIDTH;
  localparam int NOUT = W - K + 1;
  localparam int PXW  = (W > 1) ? $clog2(W) : 1;
  localparam int MW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int CHW  = (NO_IN_CHANNEL > 1) ? $clog2(NO_IN_CHANNEL) : 1;

  localparam logic [PXW-1:0] PIX_LAST  = PXW'(W - 1);
  localparam logic [PXW-1:0] PIX_FIRST = PXW'(K - 1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NO_IN_CHANNEL - 1);

  state_t               r_state, w_state_next;
  logic [PXW-1:0]       r_pix, w_pix_next;
  logic [CHW-1:0]       r_ch, w_ch_next;
  logic [ACC_WIDTH-1:0] w_p [K];
  logic [ACC_WIDTH-1:0] w_r;
  logic [ACC_WIDTH-1:0] w_rb_rd;
  logic [ACC_WIDTH-1:0] w_out_base;
  logic [ACC_WIDTH-1:0] r_psum;
  logic                 r_valid;
  logic                 r_last;
  logic [MW-1:0]        w_m;
  logic                 w_accept, w_last_pix, w_last_ch, w_win_ok;
  logic                 w_rb_wr, w_out_load;

  assign o_ready    = !r_valid | i_ready;
  assign w_accept   = i_valid & o_ready;
  assign w_last_pix = (r_pix == PIX_LAST);
  assign w_last_ch  = (r_ch == CH_LAST);
  assign w_win_ok   = (r_pix >= PIX_FIRST);
  assign w_m        = MW'(r_pix - PIX_FIRST);
  assign w_pix_next = w_last_pix ? '0 : r_pix + 1'b1;
  assign w_ch_next  = !w_last_pix ? r_ch : (w_last_ch ? '0 : r_ch + 1'b1);

  // Sign-extend every lane to accumulator width; disabled lanes contribute zero
  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_p[k] = i_enable_core[k]
             ? ACC_WIDTH'(sign_extend(SEXT_W'(i_products[PW*k +: PW]), PW))
             : '0;
    end
  end

  // Pixel and channel position, advanced only by accepted products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix <= '0;
      r_ch  <= '0;
    end else if (w_accept) begin
      r_pix <= w_pix_next;
      r_ch  <= w_ch_next;
    end
  end

  // Window chain; stale taps from the previous row are masked by the r_pix gate
  generate
    if (K > 1) begin : g_chain
      logic [ACC_WIDTH-1:0] r_s [K-1];

      // Each tap adds its lane to the running sum handed on by the previous tap
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int k = 0; k < K-1; k++) r_s[k] <= '0;
        end else if (w_accept) begin
          r_s[0] <= w_p[0];
          for (int k = 1; k < K-1; k++) r_s[k] <= r_s[k-1] + w_p[k];
        end
      end

      assign w_r = r_s[K-2] + w_p[K-1];
    end else begin : g_direct
      assign w_r = w_p[0];
    end
  endgenerate

  // Channels before the last only accumulate; the last channel feeds the output
  assign w_rb_wr    = w_accept & w_win_ok & !w_last_ch;
  assign w_out_load = w_accept & w_win_ok & w_last_ch;
  assign w_out_base = (NO_IN_CHANNEL == 1) ? '0 : w_rb_rd;

  psum_row_buffer #(
    .ACC_WIDTH (ACC_WIDTH),
    .DEPTH     (NOUT),
    .AW        (MW)
  ) u_rowbuf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_rb_wr),
    .i_addr    (w_m),
    .i_clear   (r_ch == '0),
    .i_add     (w_r),
    .o_rd_data (w_rb_rd)
  );

  // One-entry output register; load and drain in the same cycle keeps full rate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_psum  <= '0;
      r_last  <= 1'b0;
    end else if (w_out_load) begin
      r_valid <= 1'b1;
      r_psum  <= w_out_base + w_r;
      r_last  <= w_last_pix;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_psum  = r_psum;
  assign o_last  = r_last;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state: ACC once the window is full; after the final wrap, hold ACC until drained
  always_comb begin
    w_state_next = r_state;
    o_busy       = (r_state != ST_IDLE);
    if (w_accept) begin
      if (w_last_pix && w_last_ch)      w_state_next = ST_ACC;
      else if (w_pix_next >= PIX_FIRST) w_state_next = ST_ACC;
      else                              w_state_next = ST_FILL;
    end else if (r_state == ST_ACC && r_pix == '0 && r_ch == '0 && !r_valid) begin
      w_state_next = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_partial_sum_acc.sv
// Bench for partial_sum_acc: one single-channel and one two-channel instance,
// a direct-convolution reference model feeding an expected-output queue, and
// a monitor that pops and compares on every output handshake.
module tb_partial_sum_acc;

  localparam int BW = 8;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int AW = 2 * BW + 8;

  typedef struct {
    logic [AW-1:0] psum;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*BW*K-1:0] products;
  logic [K-1:0]      en;
  logic              valid, ready, sel;

  logic          iv1, ir1, rdy1, ov1, last1, busy1;
  logic          iv2, ir2, rdy2, ov2, last2, busy2;
  logic [AW-1:0] ps1, ps2;
  logic          m_ready, m_valid, m_last, m_busy;
  logic [AW-1:0] m_psum;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  exp_t sbq[$];

  int            pix = 0;
  int            ch  = 0;
  logic [AW-1:0] hist [W][K];
  logic [AW-1:0] acc  [W-K+1];

  always #5 clk = ~clk;

  assign iv1 = valid & ~sel;
  assign iv2 = valid & sel;
  assign ir1 = sel ? 1'b1 : ready;
  assign ir2 = sel ? ready : 1'b1;

  assign m_ready = sel ? rdy2  : rdy1;
  assign m_valid = sel ? ov2   : ov1;
  assign m_last  = sel ? last2 : last1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_psum  = sel ? ps2   : ps1;

  partial_sum_acc #(
    .BIT_WIDTH(BW), .NO_COL_KERNEL(K), .NO_COL_INPUT_FEATURE(W), .NO_IN_CHANNEL(1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_products(products), .i_enable_core(en),
    .i_valid(iv1), .o_ready(rdy1), .o_psum(ps1), .o_valid(ov1), .i_ready(ir1),
    .o_last(last1), .o_busy(busy1)
  );

  partial_sum_acc #(
    .BIT_WIDTH(BW), .NO_COL_KERNEL(K), .NO_COL_INPUT_FEATURE(W), .NO_IN_CHANNEL(2)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_products(products), .i_enable_core(en),
    .i_valid(iv2), .o_ready(rdy2), .o_psum(ps2), .o_valid(ov2), .i_ready(ir2),
    .o_last(last2), .o_busy(busy2)
  );

  // Reference: direct sum over the last K pixels of the row, channel-accumulated
  task automatic model_accept(input int v);
    logic [AW-1:0] r;
    int            m;
    int            nic;
    exp_t          e;
    nic = sel ? 2 : 1;
    for (int k = 0; k < K; k++) hist[pix][k] = en[k] ? AW'(v) : '0;
    if (pix >= K-1) begin
      m = pix - (K-1);
      r = '0;
      for (int k = 0; k < K; k++) r = r + hist[m+k][k];
      if (ch == 0) acc[m] = r;
      else         acc[m] = acc[m] + r;
      if (ch == nic-1) begin
        e.psum = acc[m];
        e.last = (m == W-K);
        sbq.push_back(e);
      end
    end
    pix++;
    if (pix == W) begin
      pix = 0;
      ch++;
      if (ch == nic) ch = 0;
    end
  endtask

  task automatic model_reset();
    pix = 0;
    ch  = 0;
    sbq.delete();
  endtask

  // Present one product set (all lanes = v) and hold it until accepted
  task automatic beat(input int v);
    int n;
    @(negedge clk);
    for (int k = 0; k < K; k++) products[16*k +: 16] = 16'(v);
    valid = 1'b1;
    #1;
    n = 0;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (!m_ready) begin
      bad++;
      $display("FAIL accept_timeout: o_ready=%0b required 1", m_ready);
    end else begin
      model_accept(v);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Let the output register and FSM settle, then check nothing is left over
  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (sbq.size() == 0 && !m_valid && !m_busy) break;
    end
    total++;
    if (sbq.size() != 0 || m_valid || m_busy) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d o_valid=%0b o_busy=%0b required 0/0/0",
               name, sbq.size(), m_valid, m_busy);
    end
  endtask

  // Monitor: on each output handshake pop the oldest expectation and compare
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_ps;
  exp_t          got_e;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_psum !== prev_ps) begin
          bad++;
          $display("FAIL hold_stable: o_valid=%0b o_psum=%0d required 1/%0d",
                   m_valid, $signed(m_psum), $signed(prev_ps));
        end
      end
      if (m_valid && ready) begin
        total++;
        n_out++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: o_psum=%0d required no output", $signed(m_psum));
        end else begin
          got_e = sbq.pop_front();
          if (m_psum !== got_e.psum || m_last !== got_e.last) begin
            bad++;
            $display("FAIL out_pixel: o_psum=%0d o_last=%0b required %0d/%0b",
                     $signed(m_psum), m_last, $signed(got_e.psum), got_e.last);
          end
        end
      end
      prev_stall = m_valid && !ready;
      prev_ps    = m_psum;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({ov1, last1, busy1, rdy1, ps1} !== {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_dut1: valid/last/busy/ready/psum=%b required 0001 and psum 0",
               {ov1, last1, busy1, rdy1, ps1});
    end
    total++;
    if ({ov2, last2, busy2, rdy2, ps2} !== {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_dut2: valid/last/busy/ready/psum=%b required 0001 and psum 0",
               {ov2, last2, busy2, rdy2, ps2});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ones_single();
    int n0;
    sel = 1'b0;
    n0  = n_out;
    for (int j = 0; j < W; j++) begin
      beat(1);
      if (j == K-2) begin
        total++;
        if (m_valid !== 1'b0) begin
          bad++;
          $display("FAIL ones_early_valid: o_valid=%0b required 0", m_valid);
        end
      end
      if (j == K-1) begin
        total++;
        if (m_valid !== 1'b1 || m_psum !== AW'(5)) begin
          bad++;
          $display("FAIL ones_first_out: o_valid=%0b o_psum=%0d required 1/5",
                   m_valid, $signed(m_psum));
        end
      end
    end
    wait_drain("ones");
    total++;
    if (n_out - n0 != 4) begin
      bad++;
      $display("FAIL ones_count: outputs=%0d required 4", n_out - n0);
    end
  endtask

  task automatic test_two_channel();
    int n0;
    sel = 1'b1;
    n0  = n_out;
    for (int j = 0; j < W; j++) beat(1);
    repeat (2) @(negedge clk);
    #3;
    total++;
    if (n_out != n0 || m_valid !== 1'b0 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL ch0_silent: outputs=%0d o_valid=%0b o_busy=%0b required 0/0/1",
               n_out - n0, m_valid, m_busy);
    end
    for (int j = 0; j < W; j++) begin
      beat(2);
      if (j == K-1) begin
        total++;
        if (m_psum !== AW'(15)) begin
          bad++;
          $display("FAIL ch1_first_out: o_psum=%0d required 15", $signed(m_psum));
        end
      end
    end
    wait_drain("two_ch");
    total++;
    if (n_out - n0 != 4) begin
      bad++;
      $display("FAIL two_ch_count: outputs=%0d required 4", n_out - n0);
    end
    sel = 1'b0;
  endtask

  task automatic test_enable();
    int n0;
    sel = 1'b0;
    en  = 5'b00001;
    n0  = n_out;
    for (int j = 0; j < W; j++) beat(j);
    wait_drain("enable");
    total++;
    if (n_out - n0 != 4) begin
      bad++;
      $display("FAIL enable_count: outputs=%0d required 4", n_out - n0);
    end
    en = '1;
  endtask

  task automatic test_signed();
    sel = 1'b0;
    for (int j = 0; j < W; j++) begin
      beat(-3);
      if (j == K-1) begin
        total++;
        if (m_psum !== 24'hFFFFF1) begin
          bad++;
          $display("FAIL signed_out: o_psum=%h required fffff1", m_psum);
        end
      end
    end
    wait_drain("signed");
  endtask

  task automatic test_backpressure();
    int            n0;
    logic [AW-1:0] held;
    sel = 1'b0;
    n0  = n_out;
    for (int j = 0; j < K; j++) beat(2);
    @(negedge clk);
    ready = 1'b0;
    valid = 1'b1;
    #1;
    held = m_psum;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (m_ready !== 1'b0 || m_valid !== 1'b1 || held !== AW'(10)) begin
        bad++;
        $display("FAIL bp_stall: o_ready=%0b o_valid=%0b o_psum=%0d required 0/1/10",
                 m_ready, m_valid, $signed(held));
      end
      @(negedge clk);
      #1;
    end
    ready = 1'b1;
    valid = 1'b0;
    for (int j = K; j < W; j++) beat(2);
    wait_drain("bp");
    total++;
    if (n_out - n0 != 4) begin
      bad++;
      $display("FAIL bp_count: outputs=%0d required 4", n_out - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    sel = 1'b0;
    n0  = n_out;
    for (int j = 0; j < 2*W; j++) beat(j*3 - 7);
    wait_drain("b2b");
    total++;
    if (n_out - n0 != 8) begin
      bad++;
      $display("FAIL b2b_count: outputs=%0d required 8", n_out - n0);
    end
  endtask

  task automatic test_reset_midrow();
    int n0;
    sel = 1'b0;
    for (int j = 0; j < 6; j++) beat(7);
    repeat (3) @(negedge clk);
    #3;
    total++;
    if (m_busy !== 1'b1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL midrow_busy: o_busy=%0b pending=%0d required 1/0", m_busy, sbq.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_psum !== '0) begin
      bad++;
      $display("FAIL midrow_reset: o_busy=%0b o_valid=%0b o_psum=%0d required 0/0/0",
               m_busy, m_valid, $signed(m_psum));
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    for (int j = 0; j < W; j++) beat(1);
    wait_drain("after_reset");
    total++;
    if (n_out - n0 != 4) begin
      bad++;
      $display("FAIL after_reset_count: outputs=%0d required 4", n_out - n0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d outputs", n_out);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    products = '0;
    en       = '1;
    valid    = 1'b0;
    ready    = 1'b1;
    sel      = 1'b0;
    test_reset();
    test_ones_single();
    test_two_channel();
    test_enable();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_midrow();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
